// File: rtl/sys_block_v2_pkg.sv
// Word map and address decode shared by the sys_block_v2 register slave.
// Pure declarations: no state, no latency, no flow control.
package sys_block_v2_pkg;

    localparam int IDX_UPTIME_LO = 4;
    localparam int IDX_UPTIME_HI = 5;
    localparam int IDX_CHG       = 6;
    localparam int BASE_SCRATCH  = 8;
    localparam int BASE_IN       = 32;
    localparam int BASE_OUT      = 64;

    typedef enum logic [2:0] {
        RO_CONST,
        UPTIME,
        CHG,
        SCRATCH,
        IN,
        OUT,
        UNMAPPED
    } region_e;

    // Word 7 is reserved and falls through to UNMAPPED with every other hole.
    function automatic region_e decode_region(
        input logic [6:0] idx,
        input int         n_scratch,
        input int         n_in,
        input int         n_out
    );
        int i;
        i = int'(idx);
        if (i < IDX_UPTIME_LO)                                   return RO_CONST;
        if (i == IDX_UPTIME_LO || i == IDX_UPTIME_HI)            return UPTIME;
        if (i == IDX_CHG)                                        return CHG;
        if (i >= BASE_SCRATCH && i < BASE_SCRATCH + n_scratch)   return SCRATCH;
        if (i >= BASE_IN && i < BASE_IN + n_in)                  return IN;
        if (i >= BASE_OUT && i < BASE_OUT + n_out)               return OUT;
        return UNMAPPED;
    endfunction

endpackage

// File: rtl/sys_block_v2_sync.sv
// Two-flop synchroniser for one status word plus a history stage for change detection.
// q lags d by two clocks; chg pulses for one cycle per synchronised change; no backpressure.
module sys_block_v2_sync #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         chg
);

    logic [W-1:0] r_q, r_d;
    logic [W-1:0] rr_q, rr_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        r_d    = d;
        rr_d   = r_q;
        prev_d = rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            rr_q   <= '0;
            prev_q <= '0;
        end else begin
            r_q    <= r_d;
            rr_q   <= rr_d;
            prev_q <= prev_d;
        end
    end

    assign q   = rr_q;
    assign chg = |(rr_q ^ prev_q);

endmodule

// File: rtl/sys_block_v2.sv
// Wishbone register slave: IDs, uptime, change flags, scratchpad, status inputs, control outputs.
// One response (ack or err) the cycle after acceptance; a held strobe is served on alternate cycles.
module sys_block_v2
    import sys_block_v2_pkg::*;
#(
    parameter logic [31:0] BOARD_ID  = 32'h0,
    parameter logic [31:0] REV_MAJ   = 32'h0,
    parameter logic [31:0] REV_MIN   = 32'h0,
    parameter logic [31:0] REV_RCS   = 32'h0,
    parameter int          N_SCRATCH = 4,
    parameter int          N_IN      = 8,
    parameter int          N_OUT     = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [32*N_IN-1:0]    regin,
    output logic [32*N_OUT-1:0]   regout,
    output logic [N_OUT-1:0]      regout_strb
);

    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       dat_q, dat_d;
    logic [N_OUT-1:0]  strb_q, strb_d;
    logic [63:0]       uptime_q, uptime_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [N_IN-1:0]   chg_q, chg_d;
    logic [31:0]       scratch_q [N_SCRATCH];
    logic [31:0]       scratch_d [N_SCRATCH];
    logic [31:0]       out_q [N_OUT];
    logic [31:0]       out_d [N_OUT];

    logic [6:0]        idx;
    logic [31:0]       bmask;
    logic              req;
    region_e           rgn;
    logic              adr_unused;
    logic [31:0]       in_word [N_IN];
    logic [N_IN-1:0]   in_chg;

    assign idx        = wb_adr_i[8:2];
    assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign rgn        = decode_region(idx, N_SCRATCH, N_IN, N_OUT);
    assign adr_unused = ^{wb_adr_i[31:9], wb_adr_i[1:0]};

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        sys_block_v2_sync #(.W(32)) u_sync (
            .clk (wb_clk_i),
            .rst (wb_rst_i),
            .d   (regin[32*k +: 32]),
            .q   (in_word[k]),
            .chg (in_chg[k])
        );
    end

    always_comb begin
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        strb_d    = '0;
        uptime_d  = uptime_q + 64'd1;
        shadow_d  = shadow_q;
        chg_d     = chg_q;
        scratch_d = scratch_q;
        out_d     = out_q;
        if (req) begin
            ack_d = 1'b1;
            if (wb_we_i) begin
                case (rgn)
                    CHG: chg_d = chg_q & ~(wb_dat_i[N_IN-1:0] & bmask[N_IN-1:0]);
                    SCRATCH: begin
                        for (int k = 0; k < N_SCRATCH; k++) begin
                            if (idx == 7'(BASE_SCRATCH + k))
                                scratch_d[k] = (scratch_q[k] & ~bmask) | (wb_dat_i & bmask);
                        end
                    end
                    OUT: begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (idx == 7'(BASE_OUT + k)) begin
                                out_d[k]  = (out_q[k] & ~bmask) | (wb_dat_i & bmask);
                                strb_d[k] = |wb_sel_i;
                            end
                        end
                    end
                    default: begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                    end
                endcase
            end else begin
                case (rgn)
                    RO_CONST: begin
                        case (idx[1:0])
                            2'd0:    dat_d = BOARD_ID;
                            2'd1:    dat_d = REV_MAJ;
                            2'd2:    dat_d = REV_MIN;
                            default: dat_d = REV_RCS;
                        endcase
                    end
                    UPTIME: begin
                        // Reading LO freezes HI so a LO-then-HI pair is coherent across a carry.
                        if (idx[0]) begin
                            dat_d = shadow_q;
                        end else begin
                            dat_d    = uptime_q[31:0];
                            shadow_d = uptime_q[63:32];
                        end
                    end
                    CHG: dat_d[N_IN-1:0] = chg_q;
                    SCRATCH: begin
                        for (int k = 0; k < N_SCRATCH; k++) begin
                            if (idx == 7'(BASE_SCRATCH + k)) dat_d = scratch_q[k];
                        end
                    end
                    IN: begin
                        for (int k = 0; k < N_IN; k++) begin
                            if (idx == 7'(BASE_IN + k)) dat_d = in_word[k];
                        end
                    end
                    OUT: begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (idx == 7'(BASE_OUT + k)) dat_d = out_q[k];
                        end
                    end
                    default: begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                    end
                endcase
            end
        end
        // Applied after the clear so a coincident new change keeps its flag.
        chg_d = chg_d | in_chg;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            strb_q    <= '0;
            uptime_q  <= '0;
            shadow_q  <= '0;
            chg_q     <= '0;
            scratch_q <= '{default: '0};
            out_q     <= '{default: '0};
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            strb_q    <= strb_d;
            uptime_q  <= uptime_d;
            shadow_q  <= shadow_d;
            chg_q     <= chg_d;
            scratch_q <= scratch_d;
            out_q     <= out_d;
        end
    end

    // A response already in flight is suppressed while reset is asserted.
    assign wb_ack_o    = ack_q & ~wb_rst_i;
    assign wb_err_o    = err_q & ~wb_rst_i;
    assign regout_strb = strb_q & {N_OUT{~wb_rst_i}};
    assign wb_dat_o    = dat_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign regout[32*k +: 32] = out_q[k];
    end

endmodule

// File: tb/tb_sys_block_v2.sv
// Directed bench for sys_block_v2: each task drives one scenario and checks against hand-computed values.
module tb_sys_block_v2;

    localparam int N_SCRATCH = 4;
    localparam int N_IN      = 8;
    localparam int N_OUT     = 8;

    logic                 clk = 1'b0;
    logic                 wb_rst_i = 1'b1;
    logic                 wb_cyc_i = 1'b0;
    logic                 wb_stb_i = 1'b0;
    logic                 wb_we_i = 1'b0;
    logic [3:0]           wb_sel_i = 4'h0;
    logic [31:0]          wb_adr_i = '0;
    logic [31:0]          wb_dat_i = '0;
    logic [31:0]          wb_dat_o;
    logic                 wb_ack_o;
    logic                 wb_err_o;
    logic [32*N_IN-1:0]   regin = '0;
    logic [32*N_OUT-1:0]  regout;
    logic [N_OUT-1:0]     regout_strb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sys_block_v2 #(
        .BOARD_ID (32'hB0A2_0002),
        .REV_MAJ  (32'h0000_0001),
        .REV_MIN  (32'h0000_0002),
        .REV_RCS  (32'h0000_0003),
        .N_SCRATCH(N_SCRATCH),
        .N_IN     (N_IN),
        .N_OUT    (N_OUT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .regin      (regin),
        .regout     (regout),
        .regout_strb(regout_strb)
    );

    // Called in the low phase; returns in the low phase one idle cycle after the response.
    task automatic xfer(input logic we, input logic [6:0] widx, input logic [3:0] sel,
                        input logic [31:0] wd, output logic ack, output logic err,
                        output logic [31:0] rd, output logic [N_OUT-1:0] strb);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {23'd0, widx, 2'b00}; wb_sel_i = sel; wb_dat_i = wd;
        @(posedge clk);
        @(negedge clk);
        ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; strb = regout_strb;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic a, e;
        logic [31:0] d, d2;
        logic [N_OUT-1:0] s;
        logic [31:0] ids [4];
        ids[0] = 32'hB0A2_0002; ids[1] = 32'h1; ids[2] = 32'h2; ids[3] = 32'h3;
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        wb_rst_i = 1'b0;
        vectors++; if (wb_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b want=0", wb_ack_o); end
        vectors++; if (wb_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b want=0", wb_err_o); end
        vectors++; if (wb_dat_o !== 32'h0) begin miscompares++; $display("FAIL rst_dat got=%h want=0", wb_dat_o); end
        vectors++; if (regout !== '0) begin miscompares++; $display("FAIL rst_regout got=%h want=0", regout); end
        vectors++; if (regout_strb !== '0) begin miscompares++; $display("FAIL rst_strb got=%h want=0", regout_strb); end
        xfer(1'b0, 7'd5, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL rst_uptime_hi ack=%b dat=%h want ack=1 dat=0", a, d); end
        xfer(1'b0, 7'd6, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL rst_chg ack=%b dat=%h want ack=1 dat=0", a, d); end
        xfer(1'b0, 7'd8, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL rst_scratch ack=%b dat=%h want ack=1 dat=0", a, d); end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 7'(i), 4'hF, 32'h0, a, e, d, s);
            vectors++;
            if (a !== 1'b1 || e !== 1'b0 || d !== ids[i]) begin
                miscompares++;
                $display("FAIL id_word%0d ack=%b err=%b dat=%h want ack=1 err=0 dat=%h", i, a, e, d, ids[i]);
            end
        end
        xfer(1'b0, 7'd4, 4'hF, 32'h0, a, e, d, s);
        xfer(1'b0, 7'd4, 4'hF, 32'h0, a, e, d2, s);
        vectors++; if (d2 - d !== 32'd2) begin miscompares++; $display("FAIL uptime_rate lo1=%h lo2=%h want diff 2", d, d2); end
    endtask

    task automatic test_write_out();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        xfer(1'b1, 7'd64, 4'b0101, 32'hDEADBEEF, a, e, d, s);
        vectors++; if (a !== 1'b1 || e !== 1'b0) begin miscompares++; $display("FAIL out0_wr ack=%b err=%b want 1/0", a, e); end
        vectors++; if (s !== 8'h01) begin miscompares++; $display("FAIL out0_strb got=%h want=01", s); end
        vectors++; if (regout[31:0] !== 32'h00AD00EF) begin miscompares++; $display("FAIL out0_val got=%h want=00ad00ef", regout[31:0]); end
        vectors++; if (regout_strb !== 8'h00) begin miscompares++; $display("FAIL out0_strb_once got=%h want=00", regout_strb); end
        xfer(1'b0, 7'd64, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h00AD00EF) begin miscompares++; $display("FAIL out0_rd ack=%b dat=%h want=00ad00ef", a, d); end
        xfer(1'b1, 7'd64, 4'b0000, 32'hFFFFFFFF, a, e, d, s);
        vectors++; if (a !== 1'b1 || s !== 8'h00 || regout[31:0] !== 32'h00AD00EF) begin
            miscompares++; $display("FAIL out0_sel0 ack=%b strb=%h val=%h want 1/00/00ad00ef", a, s, regout[31:0]); end
        xfer(1'b1, 7'd64, 4'b0101, 32'hDEADBEEF, a, e, d, s);
        vectors++; if (s !== 8'h01) begin miscompares++; $display("FAIL out0_same_strb got=%h want=01", s); end
        xfer(1'b1, 7'd71, 4'hF, 32'h0000_0001, a, e, d, s);
        vectors++; if (s !== 8'h80 || regout[255:224] !== 32'h1) begin
            miscompares++; $display("FAIL out7_wr strb=%h val=%h want 80/00000001", s, regout[255:224]); end
    endtask

    task automatic test_scratch();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        xfer(1'b1, 7'd9, 4'hF, 32'hA5A5_1234, a, e, d, s);
        xfer(1'b1, 7'd9, 4'b1000, 32'hFF00_0000, a, e, d, s);
        xfer(1'b0, 7'd9, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'hFFA5_1234) begin miscompares++; $display("FAIL scratch_rw ack=%b dat=%h want=ffa51234", a, d); end
    endtask

    task automatic test_errors();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        logic [6:0] bad [6];
        logic       badwe [6];
        bad[0] = 7'd2;  badwe[0] = 1'b1;
        bad[1] = 7'd7;  badwe[1] = 1'b0;
        bad[2] = 7'd72; badwe[2] = 1'b0;
        bad[3] = 7'd33; badwe[3] = 1'b1;
        bad[4] = 7'd4;  badwe[4] = 1'b1;
        bad[5] = 7'd12; badwe[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xfer(badwe[i], bad[i], 4'hF, 32'hFFFF_FFFF, a, e, d, s);
            vectors++;
            if (a !== 1'b0 || e !== 1'b1 || d !== 32'h0 || s !== 8'h00) begin
                miscompares++;
                $display("FAIL err_idx%0d ack=%b err=%b dat=%h strb=%h want 0/1/0/00", bad[i], a, e, d, s);
            end
        end
        xfer(1'b0, 7'd2, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h2) begin miscompares++; $display("FAIL err_nochange ack=%b dat=%h want=2", a, d); end
    endtask

    task automatic test_handshake();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0; wb_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (wb_ack_o !== ((i % 2) == 0) || wb_err_o !== 1'b0) begin
                miscompares++; $display("FAIL held_stb cyc%0d ack=%b err=%b want ack=%0d", i, wb_ack_o, wb_err_o, (i % 2) == 0);
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h4;
        @(posedge clk);
        #1 wb_cyc_i = 1'b0;
        @(negedge clk);
        vectors++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1) begin
            miscompares++; $display("FAIL cyc_drop ack=%b dat=%h want 1/00000001", wb_ack_o, wb_dat_o); end
        @(negedge clk);
        @(negedge clk);
        vectors++; if (wb_ack_o !== 1'b0) begin miscompares++; $display("FAIL cyc_low_no_accept ack=%b want=0", wb_ack_o); end
        wb_stb_i = 1'b0;
        xfer(1'b0, 7'd0, 4'hF, 32'h0, a, e, d, s);
    endtask

    task automatic test_chg();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        regin[3*32 +: 32] = 32'h1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        xfer(1'b0, 7'd6, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL chg_too_early got=%h want=0", d); end
        xfer(1'b0, 7'd6, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h8) begin miscompares++; $display("FAIL chg_set got=%h want=8", d); end
        xfer(1'b0, 7'd35, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h1) begin miscompares++; $display("FAIL regin3_rd ack=%b dat=%h want=1", a, d); end
        xfer(1'b1, 7'd6, 4'hF, 32'h8, a, e, d, s);
        xfer(1'b0, 7'd6, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL chg_w1c got=%h want=0", d); end
        regin[3*32 +: 32] = 32'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        xfer(1'b1, 7'd6, 4'hF, 32'h8, a, e, d, s);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL chg_w1c_ack got=%b want=1", a); end
        xfer(1'b0, 7'd6, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h8) begin miscompares++; $display("FAIL chg_set_wins got=%h want=8", d); end
    endtask

    task automatic test_uptime();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        force dut.uptime_q = 64'h0000_0001_FFFF_FFFF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'd16; wb_sel_i = 4'hF;
        @(posedge clk);
        #1 release dut.uptime_q;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        vectors++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL uptime_lo ack=%b dat=%h want ffffffff", wb_ack_o, wb_dat_o); end
        @(negedge clk);
        xfer(1'b0, 7'd5, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL uptime_hi_shadow got=%h want=1", d); end
        force dut.uptime_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1 release dut.uptime_q;
        @(posedge clk); @(negedge clk);
        xfer(1'b0, 7'd4, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL uptime_wrap_lo got=%h want=0", d); end
        xfer(1'b0, 7'd5, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL uptime_wrap_hi got=%h want=0", d); end
    endtask

    task automatic test_reset_mid();
        logic a, e;
        logic [31:0] d;
        logic [N_OUT-1:0] s;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'd260; wb_sel_i = 4'hF; wb_dat_i = 32'h1234_5678;
        @(posedge clk);
        #1 wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        vectors++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || regout_strb !== 8'h00) begin
            miscompares++; $display("FAIL rstmid_resp ack=%b err=%b strb=%h want 0/0/00", wb_ack_o, wb_err_o, regout_strb); end
        @(posedge clk);
        #1 wb_rst_i = 1'b0;
        @(negedge clk);
        vectors++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || regout !== '0) begin
            miscompares++; $display("FAIL rstmid_after ack=%b err=%b regout=%h want 0/0/0", wb_ack_o, wb_err_o, regout); end
        xfer(1'b0, 7'd65, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL rstmid_rd ack=%b dat=%h want 1/0", a, d); end
        xfer(1'b1, 7'd65, 4'hF, 32'h1234_5678, a, e, d, s);
        xfer(1'b0, 7'd65, 4'hF, 32'h0, a, e, d, s);
        vectors++; if (a !== 1'b1 || d !== 32'h1234_5678) begin miscompares++; $display("FAIL rstmid_wr ack=%b dat=%h want 12345678", a, d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_out();
        test_scratch();
        test_errors();
        test_handshake();
        test_chg();
        test_uptime();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
